// File: rtl/dense_sched_if.sv
`default_nettype none
// ============================================================================
// Module : dense_sched_if
// Brief  : Control, parameter-memory, activation and output-buffer signals of
//          the dense-layer sequencer.
// Rev    : 1.0
// ============================================================================
interface dense_sched_if #(
  parameter int DAT_W = 22,
  parameter int PAR_W = 16
);
  logic                    start;
  logic [3:0]              layer;
  logic                    busy;
  logic                    done;
  logic [3:0]              state_o;
  logic                    w_en;
  logic [6:0]              read_o;
  logic [7:0]              read_i;
  logic signed [PAR_W-1:0] w_data;
  logic signed [PAR_W-1:0] b_data;
  logic [7:0]              act_addr;
  logic signed [DAT_W-1:0] act_data;
  logic                    out_we;
  logic [6:0]              out_addr;
  logic signed [DAT_W-1:0] out_data;

  modport master (
    output start, layer, w_data, b_data, act_data,
    input  busy, done, state_o, w_en, read_o, read_i, act_addr,
           out_we, out_addr, out_data
  );

  modport slave (
    input  start, layer, w_data, b_data, act_data,
    output busy, done, state_o, w_en, read_o, read_i, act_addr,
           out_we, out_addr, out_data
  );
endinterface
`default_nettype wire

// File: rtl/dense_sched.sv
`default_nettype none
// ============================================================================
// Module : dense_sched
// Brief  : Fully-connected layer sequencer (DENSE2 256->96, DENSE1 96->96) with
//          MAC, bias, rescale and saturation. Optional macro DENSE_RELU_EN
//          clamps negative results to zero.
// Rev    : 1.0
// ============================================================================
module dense_sched #(
  parameter int DAT_W    = 22,
  parameter int PAR_W    = 16,
  parameter int FP_SHIFT = 14,
  parameter int ACC_W    = 48,
  parameter int N_IN_D2  = 256,
  parameter int N_OUT_D2 = 96,
  parameter int N_IN_D1  = 96,
  parameter int N_OUT_D1 = 96
) (
  input  logic          clk,
  input  logic          rst_n,
  dense_sched_if.slave  bus
);
  localparam int PROD_W = DAT_W + PAR_W;
  localparam logic [3:0] LAYER_D2 = 4'b1000;
  localparam logic [3:0] LAYER_D1 = 4'b1001;
  localparam logic signed [DAT_W-1:0] DAT_MAX = {1'b0, {(DAT_W-1){1'b1}}};
  localparam logic signed [DAT_W-1:0] DAT_MIN = {1'b1, {(DAT_W-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    DRAIN = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                  state, state_nx;
  logic [3:0]              layer_q;
  logic [7:0]              i_q, i_last;
  logic [6:0]              o_q, o_last;
  logic                    p_vld;
  logic signed [ACC_W-1:0] acc;
  logic                    accept;
  logic                    running;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0] bias_ext, sum, scaled;
  logic signed [DAT_W-1:0] result;

  assign accept  = bus.start && (bus.layer == LAYER_D2 || bus.layer == LAYER_D1);
  assign running = (state == ISSUE) || (state == DRAIN) || (state == WRITE);
  assign prod    = PROD_W'(bus.w_data) * PROD_W'(bus.act_data);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    bus.busy     = running;
    bus.done     = (state == DONE);
    bus.w_en     = (state == ISSUE);
    bus.state_o  = running ? layer_q : 4'd0;
    bus.read_o   = running ? o_q : 7'd0;
    bus.read_i   = running ? i_q : 8'd0;
    bus.act_addr = running ? i_q : 8'd0;
    bus.out_we   = (state == WRITE);
    bus.out_addr = (state == WRITE) ? o_q : 7'd0;
    bus.out_data = (state == WRITE) ? result : '0;
    case (state)
      IDLE:    if (accept) state_nx = ISSUE;
      ISSUE:   if (i_q == i_last) state_nx = DRAIN;
      DRAIN:   state_nx = WRITE;
      WRITE:   state_nx = (o_q == o_last) ? DONE : ISSUE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Bias is aligned to the product's Q position before the common rescale.
  always_comb begin
    bias_ext = ACC_W'(bus.b_data) <<< FP_SHIFT;
    sum      = acc + bias_ext;
    scaled   = sum >>> FP_SHIFT;
    if (scaled > ACC_W'(DAT_MAX))      result = DAT_MAX;
    else if (scaled < ACC_W'(DAT_MIN)) result = DAT_MIN;
    else                               result = scaled[DAT_W-1:0];
`ifdef DENSE_RELU_EN
    if (result < 0) result = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      layer_q <= 4'd0;
      i_q     <= 8'd0;
      i_last  <= 8'd0;
      o_q     <= 7'd0;
      o_last  <= 7'd0;
      p_vld   <= 1'b0;
      acc     <= '0;
    end else begin
      p_vld <= (state == ISSUE);
      if (p_vld) acc <= acc + ACC_W'(prod);
      case (state)
        IDLE: if (accept) begin
          layer_q <= bus.layer;
          i_last  <= (bus.layer == LAYER_D2) ? 8'(N_IN_D2 - 1)  : 8'(N_IN_D1 - 1);
          o_last  <= (bus.layer == LAYER_D2) ? 7'(N_OUT_D2 - 1) : 7'(N_OUT_D1 - 1);
          i_q     <= 8'd0;
          o_q     <= 7'd0;
          acc     <= '0;
        end
        ISSUE: if (i_q != i_last) i_q <= i_q + 8'd1;
        WRITE: begin
          acc <= '0;
          i_q <= 8'd0;
          if (o_q != o_last) o_q <= o_q + 7'd1;
        end
        DONE: begin
          layer_q <= 4'd0;
          i_q     <= 8'd0;
          o_q     <= 7'd0;
        end
        default: ;
      endcase
    end
  end
endmodule
`default_nettype wire
